// File: rtl/math_pkg.sv
// Shared definitions for the math datapath blocks.
//   state_t   : divider FSM state encoding (IDLE, RUN, FIX, DONE)
//   ceil_div  : ceiling division, used to derive STEPS = ceil(WIDTH/BITS_PER_CYCLE)
//   clog2     : ceiling log2, used to size the divider step counter
package math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/math_div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder before the step
//   dvd_bit : next dividend bit shifted into the partial remainder
//   divisor : divisor
//   rem_out : partial remainder after the step
//   q_bit   : resolved quotient bit
module math_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The trial subtraction is done on WIDTH+1 bits: the shifted remainder can
  // exceed 2^WIDTH-1, and bit WIDTH of the difference is the borrow/sign.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/math_divider_sequential.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Optional build macro: MATH_DIVIDER_SIGNED_EN (two's-complement operands,
// truncating quotient, remainder takes the dividend's sign, extra FIX cycle).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (I1 dividend, I2 divisor)
//   out_valid / out_ready : result handshake
//   quotient, remainder   : I1 / I2 and I1 % I2
//   div_by_zero           : result came from I2 == 0 (quotient all ones, remainder I1)
module math_divider_sequential
  import math_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned STEPS  = ceil_div(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CNT_W  = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t           state;
  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH-1:0] rem_r;   // partial remainder
  logic [WIDTH-1:0] dvd_r;   // dividend bits shift out the top, quotient bits fill the bottom
  logic [WIDTH-1:0] dvs_r;   // divisor (magnitude in the signed build)
  logic [WIDTH-1:0] op_a;    // dividend as fed to the datapath
  logic [WIDTH-1:0] op_b;    // divisor as fed to the datapath
  logic [WIDTH-1:0] chain_rem;
  logic [WIDTH-1:0] chain_dvd;

`ifdef MATH_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Divide magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    op_a = I1[WIDTH-1] ? -I1 : I1;
    op_b = I2[WIDTH-1] ? -I2 : I2;
  end
`else
  always_comb begin
    op_a = I1;
    op_b = I2;
  end
`endif

  // Chain of restoring steps evaluated in one clock. A stage whose bit index
  // lies beyond WIDTH (short final clock) passes its inputs through unshifted.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_stage
    logic [WIDTH-1:0] rem_i;
    logic [WIDTH-1:0] dvd_i;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] rem_o;
    logic [WIDTH-1:0] dvd_o;
    logic             q_s;
    logic             active;

    if (k == 0) begin : g_first
      assign rem_i = rem_r;
      assign dvd_i = dvd_r;
    end else begin : g_next
      assign rem_i = g_stage[k-1].rem_o;
      assign dvd_i = g_stage[k-1].dvd_o;
    end

    assign active = ((32'(step_cnt) * BITS_PER_CYCLE) + 32'(k)) < WIDTH;

    math_div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_in (rem_i),
      .dvd_bit(dvd_i[WIDTH-1]),
      .divisor(dvs_r),
      .rem_out(rem_s),
      .q_bit  (q_s)
    );

    assign rem_o = active ? rem_s : rem_i;
    assign dvd_o = active ? {dvd_i[WIDTH-2:0], q_s} : dvd_i;
  end

  assign chain_rem = g_stage[BITS_PER_CYCLE-1].rem_o;
  assign chain_dvd = g_stage[BITS_PER_CYCLE-1].dvd_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
`ifdef MATH_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (I2 == '0) begin
              quotient    <= '1;
              remainder   <= I1;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              rem_r    <= '0;
              dvd_r    <= op_a;
              dvs_r    <= op_b;
              step_cnt <= '0;
`ifdef MATH_DIVIDER_SIGNED_EN
              neg_q    <= I1[WIDTH-1] ^ I2[WIDTH-1];
              neg_r    <= I1[WIDTH-1];
`endif
              state    <= RUN;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end

        RUN: begin
          rem_r <= chain_rem;
          dvd_r <= chain_dvd;
          if (step_cnt == LAST_STEP) begin
            step_cnt <= '0;
`ifdef MATH_DIVIDER_SIGNED_EN
            state       <= FIX;
`else
            quotient    <= chain_dvd;
            remainder   <= chain_rem;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

`ifdef MATH_DIVIDER_SIGNED_EN
        FIX: begin
          quotient    <= neg_q ? -dvd_r : dvd_r;
          remainder   <= neg_r ? -rem_r : rem_r;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
`endif

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
